fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Program-counter and fetch-sequencing stage sitting directly upstream of the 32-bit `add` unit. It holds the architectural fetch PC, drives it and the step constant into the adder, and takes the adder's sum as the sequential next PC. It also issues single-outstanding instruction-memory requests and delivers fetched {pc, inst} pairs to decode through a one-entry valid/ready slot.

## Interface
- RESET_PC, 32'h8000_0000, PC value after reset (word aligned)
- STEP, 32'd4, sequential PC increment driven to the adder

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- add_data1  out  32  current PC register, to adder data1
- add_data2  out  32  constant STEP, to adder data2
- add_result  in  32  adder sum (combinational, same cycle)
- redirect_valid  in  1  branch/jump redirect request
- redirect_pc  in  32  redirect target
- stall  in  1  hold off new fetch requests
- if_req_valid  out  1  fetch request valid
- if_req_addr  out  32  fetch address
- if_req_ready  in  1  memory accepts request
- if_resp_valid  in  1  fetch response valid (≥1 cycle after accept)
- if_resp_inst  in  32  fetched instruction
- id_valid  out  1  decode slot holds an instruction
- id_pc  out  32  PC of slot instruction
- id_inst  out  32  slot instruction
- id_ready  in  1  decode consumes slot

## Operation
- States: BOOT, REQ, WAIT, DROP. Registers: pc, req_pc, state, id_valid, id_pc, id_inst.
- Reset (rst_n=0 at edge): pc=RESET_PC, state=BOOT, id_valid=0, id_pc=0, id_inst=0. req_pc=0.
- Combinational: add_data1=pc; add_data2=STEP; if_req_addr=pc; if_req_valid = (state==REQ) & !redirect_valid & !stall & (!id_valid | id_ready).
- BOOT: unconditionally → REQ next cycle (redirect in BOOT still loads pc).
- REQ: on if_req_valid & if_req_ready: req_pc<=pc, pc<=add_result, → WAIT. Otherwise stay.
- WAIT: on if_resp_valid (no redirect): id_valid<=1, id_pc<=req_pc, id_inst<=if_resp_inst, → REQ.
- Redirect (any state, highest priority): pc<=redirect_pc & 32'hFFFF_FFFC; id_valid<=0. In WAIT: → DROP, unless if_resp_valid same cycle (response discarded, → REQ). In DROP: stay DROP unless if_resp_valid same cycle (→ REQ). In REQ: stay REQ, no request issued that cycle.
- DROP: on if_resp_valid discard response (slot untouched), → REQ.
- Decode slot: id_valid clears on id_valid & id_ready when not refilled that cycle; refill and drain in same cycle leaves id_valid=1 with new data. Slot never overwritten while full (guaranteed by issue condition + single outstanding).
- stall affects only issue in REQ; WAIT/DROP proceed.
- Arithmetic: PC wraps mod 2^32 (0xFFFF_FFFC + 4 → 0x0000_0000); block never checks add_result.

## Timing
- Reset released at edge 0 → BOOT cycle 0; if_req_valid first high cycle 1 with addr RESET_PC.
- Request-to-slot latency: response cycle + 1 (id_valid visible edge after if_resp_valid).
- Max throughput: one instruction per 2 cycles with zero-wait memory (REQ, WAIT).
- Redirect applied at cycle N: earliest request to new target cycle N+1 (from REQ) or after pending response drains (from WAIT).
- rst_n low mid-fetch: all state to reset values next edge; any later response before a new request ignored (state BOOT/REQ ignore if_resp_valid).

## Test plan
- Reset, memory always ready, 1-cycle response, id_ready=1 → addrs 0x8000_0000, 0x8000_0004, 0x8000_0008 on cycles 1,3,5; id_pc matches, id_inst equals returned data.
- id_ready=0 with slot full → if_req_valid stays 0, pc frozen at next address; raise id_ready → request issued same cycle.
- Redirect to 0x0000_1002 while in WAIT, response next cycle → response dropped, id_valid=0, next request addr 0x0000_1000.
- Redirect coincident with if_resp_valid in WAIT → instruction discarded, state REQ, next addr = redirect target.
- Redirect to 0xFFFF_FFFC → requests at 0xFFFF_FFFC then 0x0000_0000 (wrap).
- stall=1 for 3 cycles in REQ → no request; rst_n=0 during WAIT → next request 0x8000_0000, stale response ignored.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Fetch PC sequencer: owns the fetch PC, uses an external adder for PC+STEP, issues one
// outstanding instruction-memory request at a time and buffers the result in a decode slot.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,

  output logic [31:0] add_data1,
  output logic [31:0] add_data2,
  input  logic [31:0] add_result,

  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,

  output logic        if_req_valid,
  output logic [31:0] if_req_addr,
  input  logic        if_req_ready,
  input  logic        if_resp_valid,
  input  logic [31:0] if_resp_inst,

  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready
);

  typedef enum logic [1:0] {StBoot, StReq, StWait, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  logic slot_free;
  logic req_fire;

  // A new request may only go out when the slot will have room for its response.
  assign slot_free    = !id_valid_q || id_ready;
  assign if_req_valid = (state_q == StReq) && !redirect_valid && !stall && slot_free;
  assign req_fire     = if_req_valid && if_req_ready;

  assign add_data1   = pc_q;
  assign add_data2   = STEP;
  assign if_req_addr = pc_q;

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;

    if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      id_valid_d = 1'b0;
      // An in-flight response must still be drained before a new request can go out.
      unique case (state_q)
        StWait, StDrop: state_d = if_resp_valid ? StReq : StDrop;
        default:        state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StBoot: begin
          state_d = StReq;
        end
        StReq: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = add_result;
            state_d  = StWait;
          end
        end
        StWait: begin
          if (if_resp_valid) begin
            id_valid_d = 1'b1;
            id_pc_d    = req_pc_q;
            id_inst_d  = if_resp_inst;
            state_d    = StReq;
          end
        end
        StDrop: begin
          if (if_resp_valid) begin
            state_d = StReq;
          end
        end
        default: begin
          state_d = StBoot;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed per-cycle vector bench for fetch_pc_gen, with the adder modelled in the bench.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst_n;
  logic [31:0] add_data1, add_data2, add_result;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        id_valid;
  logic [31:0] id_pc, id_inst;
  logic        id_ready;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .add_data1     (add_data1),
    .add_data2     (add_data2),
    .add_result    (add_result),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .if_req_valid  (if_req_valid),
    .if_req_addr   (if_req_addr),
    .if_req_ready  (if_req_ready),
    .if_resp_valid (if_resp_valid),
    .if_resp_inst  (if_resp_inst),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_ready      (id_ready)
  );

  assign add_result = add_data1 + add_data2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        stl;
    logic        rdy;
    logic        rsp;
    logic [31:0] inst;
    logic        idr;
    logic        e_rqv;
    logic [31:0] e_pc;
    logic        e_idv;
    logic [31:0] e_idpc;
    logic [31:0] e_idinst;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rv, input logic [31:0] rpc, input logic stl,
                         input logic rdy, input logic rsp, input logic [31:0] inst,
                         input logic idr, input logic e_rqv, input logic [31:0] e_pc,
                         input logic e_idv, input logic [31:0] e_idpc,
                         input logic [31:0] e_idinst);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.stl = stl; v.rdy = rdy; v.rsp = rsp; v.inst = inst;
    v.idr = idr; v.e_rqv = e_rqv; v.e_pc = e_pc; v.e_idv = e_idv;
    v.e_idpc = e_idpc; v.e_idinst = e_idinst;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic stl,
                       input logic rdy, input logic rsp, input logic [31:0] inst,
                       input logic idr);
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = stl;
    if_req_ready   = rdy;
    if_resp_valid  = rsp;
    if_resp_inst   = inst;
    id_ready       = idr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // rv rpc stall rdy rsp inst idr | rqv pc idv idpc idinst
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         1, 0, 32'h8000_0000, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         1, 1, 32'h8000_0000, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 1, 32'h1111_0000, 1, 0, 32'h8000_0004, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         1, 1, 32'h8000_0004, 1,
            32'h8000_0000, 32'h1111_0000);
    add_vec(0, 32'h0,         0, 1, 1, 32'h2222_0004, 1, 0, 32'h8000_0008, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         1, 1, 32'h8000_0008, 1,
            32'h8000_0004, 32'h2222_0004);
    add_vec(0, 32'h0,         0, 1, 1, 32'h3333_0008, 0, 0, 32'h8000_000C, 0, 0, 0);
    // Slot full and decode not ready: issue held off, pc frozen.
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         0, 0, 32'h8000_000C, 1,
            32'h8000_0008, 32'h3333_0008);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         0, 0, 32'h8000_000C, 1,
            32'h8000_0008, 32'h3333_0008);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         1, 1, 32'h8000_000C, 1,
            32'h8000_0008, 32'h3333_0008);
    // Redirect in WAIT, response arrives in DROP and is discarded.
    add_vec(1, 32'h0000_1002, 0, 1, 0, 32'h0,         1, 0, 32'h8000_0010, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 1, 32'hDEAD_BEEF, 1, 0, 32'h0000_1000, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         1, 1, 32'h0000_1000, 0, 0, 0);
    // Redirect coincident with the response in WAIT.
    add_vec(1, 32'h0000_2000, 0, 1, 1, 32'hCAFE_0000, 1, 0, 32'h0000_1004, 0, 0, 0);
    add_vec(0, 32'h0,         0, 0, 0, 32'h0,         1, 1, 32'h0000_2000, 0, 0, 0);
    // Redirect in REQ to the top word, then wrap.
    add_vec(1, 32'hFFFF_FFFF, 0, 1, 0, 32'h0,         1, 0, 32'h0000_2000, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 1, 32'h4444_FFFC, 1, 0, 32'h0000_0000, 0, 0, 0);
    // Stall for three cycles in REQ.
    add_vec(0, 32'h0,         1, 1, 0, 32'h0,         1, 0, 32'h0000_0000, 1,
            32'hFFFF_FFFC, 32'h4444_FFFC);
    add_vec(0, 32'h0,         1, 1, 0, 32'h0,         1, 0, 32'h0000_0000, 0, 0, 0);
    add_vec(0, 32'h0,         1, 1, 0, 32'h0,         1, 0, 32'h0000_0000, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         1, 1, 32'h0000_0000, 0, 0, 0);
    add_vec(0, 32'h0,         0, 1, 0, 32'h0,         1, 0, 32'h0000_0004, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset if_req_valid", 32'(if_req_valid), 32'h0);
    check("reset id_valid",     32'(id_valid),     32'h0);
    check("reset id_pc",        id_pc,             32'h0);
    check("reset id_inst",      id_inst,           32'h0);
    check("reset add_data1",    add_data1,         32'h8000_0000);
    check("reset add_data2",    add_data2,         32'd4);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(vecs[i].rv, vecs[i].rpc, vecs[i].stl, vecs[i].rdy, vecs[i].rsp, vecs[i].inst,
            vecs[i].idr);
      #1;
      check($sformatf("row%0d if_req_valid", i), 32'(if_req_valid), 32'(vecs[i].e_rqv));
      check($sformatf("row%0d add_data1", i),    add_data1,          vecs[i].e_pc);
      check($sformatf("row%0d if_req_addr", i),  if_req_addr,        vecs[i].e_pc);
      check($sformatf("row%0d id_valid", i),     32'(id_valid),      32'(vecs[i].e_idv));
      if (vecs[i].e_idv) begin
        check($sformatf("row%0d id_pc", i),   id_pc,   vecs[i].e_idpc);
        check($sformatf("row%0d id_inst", i), id_inst, vecs[i].e_idinst);
      end
    end

    // Reset while a response is outstanding; the late response must be ignored.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 0, 1'b1, 32'h5555_0004, 1'b1);
    #1;
    check("rst boot if_req_valid", 32'(if_req_valid), 32'h0);
    check("rst boot pc",           add_data1,         32'h8000_0000);
    check("rst boot id_valid",     32'(id_valid),     32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h6666_0000, 1'b1);
    #1;
    check("rst req if_req_valid",  32'(if_req_valid), 32'h1);
    check("rst req addr",          if_req_addr,       32'h8000_0000);
    check("rst req id_valid",      32'(id_valid),     32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    check("rst stale id_valid",    32'(id_valid),     32'h0);
    check("rst stale if_req_valid", 32'(if_req_valid), 32'h1);
    check("rst stale addr",        if_req_addr,       32'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
